// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU float format and the fp_to_int converter.
// Float layout: sign[31], exponent[30:24] biased by 63, fraction[23:0] with hidden 1.
package fpu_pkg;

  localparam int EXP_W    = 7;
  localparam int FRAC_W   = 24;
  localparam int EXP_BIAS = 63;

  // Status word bit positions.
  localparam int ST_EXACT   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_INEXACT = 3;

  // Exponent at which the significand already sits at integer weight.
  localparam logic [EXP_W-1:0] ALIGN_EXP  = EXP_W'(EXP_BIAS + FRAC_W);
  localparam logic [EXP_W-1:0] OVF_EXP    = EXP_W'(EXP_BIAS + FRAC_W + 7);
  localparam logic [4:0]       MAX_RSHIFT = 5'(FRAC_W + 2);
  localparam logic [31:0]      MIN_INT_FP = 32'hDE00_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_OVF    = 2'd2
  } fp_class_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational field split and classification of a float operand, producing
// the alignment shift direction and distance for the iterative shifter.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]     a,
  output logic            sign,
  output logic [FRAC_W:0] sig,
  output fp_class_t       cls,
  output logic            shift_left,
  output logic [4:0]      k
);

  logic [EXP_W-1:0] expo;
  logic [EXP_W-1:0] rdist;

  assign sign  = a[31];
  assign expo  = a[30:24];
  assign sig   = {1'b1, a[FRAC_W-1:0]};
  assign rdist = ALIGN_EXP - expo;

  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    cls        = CLS_NORMAL;
    shift_left = 1'b0;
    k          = 5'd0;
    if (expo == '0) begin
      cls = CLS_ZERO;
    end else if (a == MIN_INT_FP) begin
      // -2^31 is the one value with exponent 94 that still fits.
      shift_left = 1'b1;
      k          = 5'd7;
    end else if (expo >= OVF_EXP) begin
      cls = CLS_OVF;
    end else if (expo >= ALIGN_EXP) begin
      shift_left = 1'b1;
      k          = 5'(expo - ALIGN_EXP);
    end else begin
      k = (rdist > {2'b00, MAX_RSHIFT}) ? MAX_RSHIFT : rdist[4:0];
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// Float-to-signed-int32 converter with valid/ready handshakes and a one-bit-per-cycle
// alignment shifter. Define FP_TO_INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  state_t    state, state_next;

  logic            u_sign;
  logic [FRAC_W:0] u_sig;
  fp_class_t       u_cls;
  logic            u_left;
  logic [4:0]      u_k;

  logic        sign_q, zero_q, ovf_q, left_q;
  logic [4:0]  cnt_q;
  logic [31:0] mag_q;
  logic        guard_q, sticky_q;

  logic        lost, inc;
  logic [31:0] mag_rnd;
  logic [31:0] rnd_data;
  logic [3:0]  rnd_status;

  fp_unpack u_unpack (
    .a          (a),
    .sign       (u_sign),
    .sig        (u_sig),
    .cls        (u_cls),
    .shift_left (u_left),
    .k          (u_k)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = (u_k == 5'd0) ? ROUND : ALIGN;
      ALIGN:   if (cnt_q == 5'd1) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      left_q     <= 1'b0;
      cnt_q      <= '0;
      mag_q      <= '0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sign_q   <= u_sign;
          zero_q   <= (u_cls == CLS_ZERO);
          ovf_q    <= (u_cls == CLS_OVF);
          left_q   <= u_left;
          cnt_q    <= u_k;
          mag_q    <= (u_cls == CLS_NORMAL) ? {7'b0, u_sig} : '0;
          guard_q  <= 1'b0;
          sticky_q <= 1'b0;
        end
        ALIGN: begin
          cnt_q <= cnt_q - 5'd1;
          if (left_q) begin
            mag_q <= mag_q << 1;
          end else begin
            mag_q    <= mag_q >> 1;
            guard_q  <= mag_q[0];
            sticky_q <= sticky_q | guard_q;
          end
        end
        ROUND: begin
          data_out   <= rnd_data;
          status_out <= rnd_status;
        end
        default: ;
      endcase
    end
  end

  assign lost = guard_q | sticky_q;

`ifdef FP_TO_INT_ROUND_NEAREST_EN
  // Right-shift results stay below 2^24, so this increment never wraps.
  assign inc = guard_q & (sticky_q | mag_q[0]);
`else
  assign inc = 1'b0;
`endif

  assign mag_rnd = mag_q + {31'b0, inc};

  always_comb begin
    rnd_data   = '0;
    rnd_status = '0;
    if (ovf_q) begin
      rnd_data           = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      rnd_status[ST_OVF] = 1'b1;
    end else begin
      rnd_data               = sign_q ? -mag_rnd : mag_rnd;
      rnd_status[ST_EXACT]   = ~lost;
      rnd_status[ST_INEXACT] = lost;
      rnd_status[ST_UNF]     = (mag_rnd == '0) && !zero_q;
    end
  end

endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: a driver pushes hand-computed expectations,
// a monitor pops and compares on each new result, plus backpressure and reset cases.
module tb_fp_to_int;

`ifdef FP_TO_INT_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  typedef struct {
    logic [31:0] a;
    logic [31:0] data;
    logic [3:0]  st;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_ov = 1'b0;

  fp_to_int dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: each rising out_valid is one result; latency counts edges from accept inclusive.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("data[%h]", e.a), data_out, e.data);
        check($sformatf("status[%h]", e.a), {28'b0, status_out}, {28'b0, e.st});
        if (e.lat != 0)
          check($sformatf("latency[%h]", e.a), cyc - e.acc + 1, e.lat);
      end
    end
    prev_ov = out_valid;
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] d, input logic [3:0] s,
                       input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    a_in     = av;
    in_valid = 1'b1;
    sb.push_back('{av, d, s, lat, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic conv(input logic [31:0] av, input logic [31:0] d, input logic [3:0] s,
                      input int lat);
    issue(av, d, s, lat);
    drain();
  endtask

  initial begin
    int bad;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_data", data_out, 32'd0);
    check("reset_status", {28'b0, status_out}, 32'd0);
    reset = 1'b0;

    // Exact and rounding cases.
    conv(32'h3F00_0000, 32'd1, 4'b0001, 26);
    conv(32'h4000_0000, 32'd2, 4'b0001, 25);
    conv(32'h3F80_0000, RNE ? 32'd2 : 32'd1, 4'b1000, 26);
    conv(32'h4040_0000, 32'd2, 4'b1000, 25);
    conv(32'h3E80_0000, RNE ? 32'd1 : 32'd0, RNE ? 4'b1000 : 4'b1100, 27);
    conv(32'h3F40_0000, 32'd1, 4'b1000, 26);
    conv(32'h3E00_0000, 32'd0, 4'b1100, 27);
    conv(32'h3D00_0000, 32'd0, 4'b1100, 28);
    conv(32'h0100_0000, 32'd0, 4'b1100, 28);
    conv(32'h5600_0001, 32'h0080_0000, 4'b1000, 3);
    conv(32'hBF00_0000, 32'hFFFF_FFFF, 4'b0001, 26);
    conv(32'hBF80_0000, RNE ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 4'b1000, 26);
    conv(32'hC040_0000, 32'hFFFF_FFFE, 4'b1000, 25);
    // Range edges.
    conv(32'h5700_0000, 32'h0100_0000, 4'b0001, 2);
    conv(32'hD700_0001, 32'hFEFF_FFFF, 4'b0001, 2);
    conv(32'h5DFF_FFFF, 32'h7FFF_FFC0, 4'b0001, 8);
    conv(32'hDE00_0000, 32'h8000_0000, 4'b0001, 9);
    conv(32'h5E00_0000, 32'h7FFF_FFFF, 4'b0010, 2);
    conv(32'h64FF_FFFF, 32'h7FFF_FFFF, 4'b0010, 2);
    conv(32'hDE00_0001, 32'h8000_0000, 4'b0010, 2);
    conv(32'h0000_0000, 32'd0, 4'b0001, 2);
    conv(32'h8000_0000, 32'd0, 4'b0001, 2);

    // Backpressure: result must hold while a new in_valid is ignored.
    out_ready = 1'b0;
    issue(32'h4000_0000, 32'd2, 4'b0001, 25);
    drain();
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      a_in     = 32'h3F00_0000;
      @(negedge clk);
      if (data_out !== 32'd2 || status_out !== 4'b0001 || in_ready !== 1'b0 || out_valid !== 1'b1)
        bad++;
    end
    check("backpressure_violations", bad, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("post_handshake_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_handshake_out_valid", {31'b0, out_valid}, 32'd0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) n++;
    end
    check("ignored_input_no_output", n, 32'd0);

    // Reset during ALIGN discards the pending conversion.
    issue(32'h3F00_0000, 32'd1, 4'b0001, 26);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_data", data_out, 32'd0);
    check("midreset_status", {28'b0, status_out}, 32'd0);
    reset = 1'b0;
    sb.delete();
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) n++;
    end
    check("midreset_no_output", n, 32'd0);
    conv(32'h3F00_0000, 32'd1, 4'b0001, 26);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
